// File: rtl/spad_reg_fifo_pkg.sv
// Shared definitions for the scratchpad register FIFO family.
// Default geometry, log2 helper, status-register bit positions and the per-edge operation code.
// Pure declarations; no timing or flow-control behaviour of its own.
package spad_reg_fifo_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_DEPTH  = 4;

   // Error-flag bit positions when packed into a status register
   localparam int ERR_OVF_BIT = 0;
   localparam int ERR_UDF_BIT = 1;
   localparam int ERR_W       = 2;

   // Ceiling log2, usable in parameter expressions
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Accepted operations at one falling edge: {push_ok, pop_ok}
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/spad_reg_fifo_ptr_wrap.sv
// Circular pointer for a FIFO of arbitrary DEPTH, wrapping DEPTH-1 -> 0 by explicit compare.
// Updates on the falling clock edge; new value visible right after the edge.
// No flow control: advances whenever inc is high, clr has priority.
module spad_reg_fifo_ptr_wrap #(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   // Pointer register: clear, or advance with wrap at the last slot
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/spad_reg_fifo.sv
// Register FIFO for PE scratchpads and inter-PE links, show-ahead head on q, sticky error flags.
// Falling-edge state; a push into an empty FIFO shows on q right after that edge (no bypass).
// push is accepted while not full or when paired with a pop; rejected pushes/pops set sticky flags.
module spad_reg_fifo
   import spad_reg_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int CNT_W  = clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] d,
   input  logic              pop,
   output logic [DATA_W-1:0] q,
   output logic              empty,
   output logic              full,
   output logic [CNT_W-1:0]  count,
   output logic              err_ovf,
   output logic              err_udf
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  cnt;
   logic [ERR_W-1:0]  err;
   logic              push_ok;
   logic              pop_ok;
   fifo_op_e          op;

   // Status is derived purely from the registered occupancy
   assign empty = (cnt == '0);
   assign full  = (cnt == CNT_W'(DEPTH));

   // A pop frees the slot a same-edge push lands in, so full does not block a paired push
   assign push_ok = push & (~full | pop);
   assign pop_ok  = pop & ~empty;
   assign op      = fifo_op_e'({push_ok, pop_ok});

   // Show-ahead head, forced to zero so stale storage never leaks out when empty
   assign q = empty ? '0 : mem[rd_ptr];

   assign count   = cnt;
   assign err_ovf = err[ERR_OVF_BIT];
   assign err_udf = err[ERR_UDF_BIT];

   spad_reg_fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .inc   (push_ok & ~flush),
      .ptr   (wr_ptr)
   );

   spad_reg_fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .inc   (pop_ok & ~flush),
      .ptr   (rd_ptr)
   );

   // Storage write; contents are intentionally not reset
   always_ff @(negedge clk) begin
      if (push_ok && !flush) begin
         mem[wr_ptr] <= d;
      end
   end

   // Occupancy: flush wins, a paired push+pop leaves it unchanged
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else begin
         case (op)
            OP_PUSH: cnt <= cnt + 1'b1;
            OP_POP:  cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Sticky error flags, cleared only by flush or reset
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= '0;
      end else if (flush) begin
         err <= '0;
      end else begin
         if (push && full && !pop) begin
            err[ERR_OVF_BIT] <= 1'b1;
         end
         if (pop && empty) begin
            err[ERR_UDF_BIT] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spad_reg_fifo.sv
// Bench for spad_reg_fifo: DEPTH=4/16-bit and DEPTH=3/8-bit instances checked against queue models.
// Inputs change just after posedge, the DUT acts on negedge, outputs are compared at posedge.
// Directed vectors with literal expectations pin the model.
module tb_spad_reg_fifo;

   logic clk;
   logic rst_n;

   logic        flush4, push4, pop4;
   logic [15:0] d4, q4;
   logic        empty4, full4, ovf4, udf4;
   logic [2:0]  count4;

   logic        flush3, push3, pop3;
   logic [7:0]  d3, q3;
   logic        empty3, full3, ovf3, udf3;
   logic [1:0]  count3;

   int checks = 0;
   int errors = 0;
   bit run    = 0;

   spad_reg_fifo #(.DATA_W(16), .DEPTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .flush(flush4), .push(push4), .d(d4), .pop(pop4),
      .q(q4), .empty(empty4), .full(full4), .count(count4), .err_ovf(ovf4), .err_udf(udf4)
   );

   spad_reg_fifo #(.DATA_W(8), .DEPTH(3)) u3 (
      .clk(clk), .rst_n(rst_n), .flush(flush3), .push(push3), .d(d3), .pop(pop3),
      .q(q3), .empty(empty3), .full(full3), .count(count3), .err_ovf(ovf3), .err_udf(udf3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference models: a queue per instance plus sticky flags
   logic [15:0] m4[$];
   logic [7:0]  m3[$];
   bit mo4, mu4, mo3, mu3;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m4.delete(); mo4 = 0; mu4 = 0;
      end else if (flush4) begin
         m4.delete(); mo4 = 0; mu4 = 0;
      end else begin
         bit f, e;
         f = (m4.size() == 4);
         e = (m4.size() == 0);
         if (push4 && f && !pop4) mo4 = 1;
         if (pop4 && e) mu4 = 1;
         if (pop4 && !e) void'(m4.pop_front());
         if (push4 && (!f || pop4)) m4.push_back(d4);
      end
   end

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m3.delete(); mo3 = 0; mu3 = 0;
      end else if (flush3) begin
         m3.delete(); mo3 = 0; mu3 = 0;
      end else begin
         bit f, e;
         f = (m3.size() == 3);
         e = (m3.size() == 0);
         if (push3 && f && !pop3) mo3 = 1;
         if (pop3 && e) mu3 = 1;
         if (pop3 && !e) void'(m3.pop_front());
         if (push3 && (!f || pop3)) m3.push_back(d3);
      end
   end

   // Every-cycle comparison of both instances against their models
   always @(posedge clk) begin
      if (run) begin
         chk("q4",     32'(q4),     (m4.size() != 0) ? 32'(m4[0]) : 32'd0);
         chk("count4", 32'(count4), 32'(m4.size()));
         chk("empty4", 32'(empty4), 32'(m4.size() == 0));
         chk("full4",  32'(full4),  32'(m4.size() == 4));
         chk("ovf4",   32'(ovf4),   32'(mo4));
         chk("udf4",   32'(udf4),   32'(mu4));
         chk("q3",     32'(q3),     (m3.size() != 0) ? 32'(m3[0]) : 32'd0);
         chk("count3", 32'(count3), 32'(m3.size()));
         chk("empty3", 32'(empty3), 32'(m3.size() == 0));
         chk("full3",  32'(full3),  32'(m3.size() == 3));
         chk("ovf3",   32'(ovf3),   32'(mo3));
         chk("udf3",   32'(udf3),   32'(mu3));
         chk("ptr3_range", 32'((u3.wr_ptr <= 2'd2) && (u3.rd_ptr <= 2'd2)), 32'd1);
      end
   end

   // One falling edge of activity on the 4-deep instance
   task automatic op4(input logic p, input logic po, input logic [15:0] dat, input logic f);
      push4 = p; pop4 = po; d4 = dat; flush4 = f;
      @(posedge clk); #1;
      push4 = 0; pop4 = 0; d4 = '0; flush4 = 0;
   endtask

   task automatic op3(input logic p, input logic po, input logic [7:0] dat);
      push3 = p; pop3 = po; d3 = dat; flush3 = 0;
      @(posedge clk); #1;
      push3 = 0; pop3 = 0; d3 = '0;
   endtask

   // Test 5 vectors: {push, pop}
   logic [1:0] vec5 [10] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b01,
                             2'b10, 2'b11, 2'b01, 2'b01, 2'b10};

   initial begin
      rst_n = 0;
      flush4 = 0; push4 = 0; pop4 = 0; d4 = '0;
      flush3 = 0; push3 = 0; pop3 = 0; d3 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count4), 32'd0);
      chk("rst_empty", 32'(empty4), 32'd1);
      chk("rst_q",     32'(q4),     32'd0);
      rst_n = 1;
      run = 1;
      @(posedge clk); #1;

      // 1: reset mid-stream
      op4(1, 0, 16'h0011, 0);
      op4(1, 0, 16'h0022, 0);
      op4(1, 0, 16'h0033, 0);
      chk("t1_pre_count", 32'(count4), 32'd3);
      rst_n = 0;
      #1;
      chk("t1_rst_count", 32'(count4), 32'd0);
      chk("t1_rst_empty", 32'(empty4), 32'd1);
      chk("t1_rst_q",     32'(q4),     32'd0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      op4(1, 0, 16'hAAAA, 0);
      chk("t1_q",     32'(q4),     32'h0000AAAA);
      chk("t1_count", 32'(count4), 32'd1);
      op4(0, 1, '0, 0);

      // 2: fill and drain
      for (int i = 1; i <= 4; i++) op4(1, 0, 16'(i), 0);
      chk("t2_full",  32'(full4),  32'd1);
      chk("t2_count", 32'(count4), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         chk("t2_drain_q", 32'(q4), 32'(i));
         op4(0, 1, '0, 0);
      end
      chk("t2_empty", 32'(empty4), 32'd1);
      chk("t2_q0",    32'(q4),     32'd0);
      chk("t2_flags", 32'({ovf4, udf4}), 32'd0);

      // 3: push+pop while full
      for (int i = 1; i <= 4; i++) op4(1, 0, 16'(i), 0);
      chk("t3_head", 32'(q4), 32'd1);
      op4(1, 1, 16'h0005, 0);
      chk("t3_count", 32'(count4), 32'd4);
      chk("t3_q",     32'(q4),     32'd2);
      chk("t3_ovf",   32'(ovf4),   32'd0);
      for (int i = 2; i <= 5; i++) begin
         chk("t3_drain_q", 32'(q4), 32'(i));
         op4(0, 1, '0, 0);
      end

      // 4: overflow and underflow flags
      for (int i = 1; i <= 4; i++) op4(1, 0, 16'(i), 0);
      op4(1, 0, 16'h0009, 0);
      chk("t4_ovf",   32'(ovf4),   32'd1);
      chk("t4_count", 32'(count4), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         chk("t4_drain_q", 32'(q4), 32'(i));
         op4(0, 1, '0, 0);
      end
      op4(0, 1, '0, 0);
      chk("t4_udf",       32'(udf4),   32'd1);
      chk("t4_ovf_hold",  32'(ovf4),   32'd1);
      chk("t4_count0",    32'(count4), 32'd0);
      op4(0, 0, '0, 0);
      chk("t4_udf_hold",  32'(udf4),   32'd1);
      op4(1, 1, 16'h7777, 1);
      chk("t4_flush_flags", 32'({ovf4, udf4}), 32'd0);
      chk("t4_flush_empty", 32'(empty4), 32'd1);

      // 6: empty + push + pop in one cycle
      op4(1, 1, 16'h1234, 0);
      chk("t6_q",     32'(q4),     32'h00001234);
      chk("t6_count", 32'(count4), 32'd1);
      chk("t6_udf",   32'(udf4),   32'd1);
      op4(0, 0, '0, 1);

      // 5: DEPTH=3 wrap, pushes carry 0x10, 0x11, ...
      begin
         logic [7:0] nxt;
         nxt = 8'h10;
         for (int c = 0; c < 10; c++) begin
            op3(vec5[c][1], vec5[c][0], nxt);
            if (vec5[c][1]) nxt = nxt + 8'd1;
            if (c == 3) chk("t5_q_c4", 32'(q3), 32'h11);
            if (c == 8) chk("t5_q_c9", 32'(q3), 32'h15);
         end
         chk("t5_count", 32'(count3), 32'd2);
         chk("t5_drain0", 32'(q3), 32'h15);
         op3(0, 1, '0);
         chk("t5_drain1", 32'(q3), 32'h16);
         op3(0, 1, '0);
         chk("t5_empty", 32'(empty3), 32'd1);
      end

      repeat (2) @(posedge clk);
      #1;
      run = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
